// File: rtl/hamming_secded_dec.sv
// Two-stage streaming SECDED Hamming decoder with valid/ready on both sides
// and saturating single/double error event counters.
module hamming_secded_dec #(
  parameter int unsigned DW   = 512,
  parameter int unsigned CNTW = 16,
  localparam int unsigned P   = $clog2(DW + $clog2(DW + 1) + 1),
  localparam int unsigned CW  = DW + P + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [CW-1:0]   i_cw,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [DW-1:0]   o_data,
  output logic            o_sec,
  output logic            o_ded,
  input  logic            i_clr_cnt,
  output logic [CNTW-1:0] o_sec_cnt,
  output logic [CNTW-1:0] o_ded_cnt
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Codeword position of data bit j: the j-th non-power-of-two index above 0.
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned i = 1; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == j) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic          en;
  logic [P-1:0]  syn_c;
  logic          par_c;
  logic [DW-1:0] in_data_c;

  logic          s1_valid;
  logic [DW-1:0] s1_data;
  logic [P-1:0]  s1_syn;
  logic          s1_par;

  logic          syn_nz_c;
  logic          syn_ok_c;
  logic          fix_c;
  logic          sec_c;
  logic          ded_c;
  logic [DW-1:0] data_c;

  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  // Syndrome bit k is the parity of every position whose index has bit k set.
  for (genvar k = 0; k < P; k++) begin : g_syn
    logic [CW-1:0] sel;
    for (genvar i = 0; i < CW; i++) begin : g_bit
      localparam bit HIT = (i != 0) && (((i >> k) & 1) == 1);
      assign sel[i] = HIT ? i_cw[i] : 1'b0;
    end
    assign syn_c[k] = ^sel;
  end

  assign par_c = ^i_cw;

  // Only the data field travels forward; check bits are fully summarised by syn/par.
  for (genvar j = 0; j < DW; j++) begin : g_in_data
    localparam int unsigned POS = data_pos(j);
    assign in_data_c[j] = i_cw[POS];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (en) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_data <= in_data_c;
        s1_syn  <= syn_c;
        s1_par  <= par_c;
      end
    end
  end

  // Error classification from the registered syndrome and overall parity.
  always_comb begin
    syn_nz_c = (s1_syn != '0);
    syn_ok_c = (32'(s1_syn) < CW);
    fix_c    = s1_par & syn_nz_c & syn_ok_c;
    sec_c    = s1_par & (~syn_nz_c | syn_ok_c);
    ded_c    = (s1_par & ~syn_ok_c) | (~s1_par & syn_nz_c);
  end

  // A correctable syndrome pointing at a data position flips that data bit.
  for (genvar j = 0; j < DW; j++) begin : g_fix
    localparam int unsigned POS = data_pos(j);
    assign data_c[j] = s1_data[j] ^ (fix_c & (s1_syn == P'(POS)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sec   <= 1'b0;
      o_ded   <= 1'b0;
    end else if (en) begin
      o_valid <= s1_valid;
      o_data  <= data_c;
      o_sec   <= s1_valid & sec_c;
      o_ded   <= s1_valid & ded_c;
    end
  end

  // Event counters count accepted beats; clear wins over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_sec_cnt <= '0;
      o_ded_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_sec_cnt <= '0;
      o_ded_cnt <= '0;
    end else begin
      if (o_valid && i_ready && o_sec && (o_sec_cnt != CNT_MAX))
        o_sec_cnt <= o_sec_cnt + CNTW'(1);
      if (o_valid && i_ready && o_ded && (o_ded_cnt != CNT_MAX))
        o_ded_cnt <= o_ded_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Self-checking bench for hamming_secded_dec: directed vectors, random streams
// against a behavioural encode/decode model, backpressure, counters and reset.
module tb_hamming_secded_dec;

  localparam int DW      = 512;
  localparam int CNTW    = 2;
  localparam int P       = $clog2(DW + $clog2(DW + 1) + 1);
  localparam int CW      = DW + P + 1;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          sec;
    logic          ded;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            i_valid;
  logic            o_ready;
  logic [CW-1:0]   i_cw;
  logic            o_valid;
  logic            i_ready;
  logic [DW-1:0]   o_data;
  logic            o_sec;
  logic            o_ded;
  logic            i_clr_cnt;
  logic [CNTW-1:0] o_sec_cnt;
  logic [CNTW-1:0] o_ded_cnt;

  int errors;
  int checks;
  int m_sec;
  int m_ded;
  logic [CW-1:0] cw_q[$];

  hamming_secded_dec #(.DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_cw(i_cw), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_sec(o_sec), .o_ded(o_ded), .i_clr_cnt(i_clr_cnt),
    .o_sec_cnt(o_sec_cnt), .o_ded_cnt(o_ded_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int j;
    int s;
    c = '0; j = 0; s = 0;
    for (int i = 1; i < CW; i++)
      if ((i & (i - 1)) != 0) begin c[i] = d[j]; j++; end
    for (int i = 1; i < CW; i++) if (c[i]) s = s ^ i;
    for (int k = 0; k < P; k++) c[1 << k] = s[k];
    c[0] = ^c;
    return c;
  endfunction

  function automatic exp_t ref_decode(input logic [CW-1:0] cw);
    exp_t e;
    logic [CW-1:0] c;
    int s;
    int p;
    int j;
    c = cw; s = 0; p = 0;
    for (int i = 0; i < CW; i++)
      if (c[i]) begin p = p ^ 1; s = s ^ i; end
    e.sec = 1'b0; e.ded = 1'b0;
    if (p == 1) begin
      if (s == 0) e.sec = 1'b1;
      else if (s < CW) begin c[s] = ~c[s]; e.sec = 1'b1; end
      else e.ded = 1'b1;
    end else if (s != 0) e.ded = 1'b1;
    j = 0;
    e.data = '0;
    for (int i = 1; i < CW; i++)
      if ((i & (i - 1)) != 0) begin e.data[j] = c[i]; j++; end
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [CW-1:0] flip_bits(input logic [CW-1:0] cw, input int n);
    logic [CW-1:0] c;
    int pos;
    c = cw;
    for (int f = 0; f < n; f++) begin
      pos = $urandom_range(0, CW - 1);
      c[pos] = ~c[pos];
    end
    return c;
  endfunction

  task automatic upd_model(input logic sec, input logic ded, input bit clr);
    if (clr) begin
      m_sec = 0; m_ded = 0;
    end else begin
      if (sec && m_sec < CNT_MAX) m_sec++;
      if (ded && m_ded < CNT_MAX) m_ded++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_sec !== 1'b0 || o_ded !== 1'b0 ||
        o_sec_cnt !== '0 || o_ded_cnt !== '0 || o_ready !== 1'b1)
      begin errors++; $display("FAIL reset_state: valid=%b sec=%b ded=%b cnt=%0d/%0d ready=%b, want all 0 and ready=1",
                               o_valid, o_sec, o_ded, o_sec_cnt, o_ded_cnt, o_ready); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1)
      begin errors++; $display("FAIL reset_release: valid=%b ready=%b, want 0/1", o_valid, o_ready); end
  endtask

  // One isolated beat with exact latency and counter-update timing.
  task automatic single_beat(input logic [CW-1:0] cw, input string name);
    exp_t e;
    e = ref_decode(cw);
    @(negedge clk); i_valid = 1'b1; i_cw = cw; i_ready = 1'b1;
    @(negedge clk); i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b0)
      begin errors++; $display("FAIL %s_early: o_valid=%b one cycle after accept, want 0", name, o_valid); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== e.data || o_sec !== e.sec || o_ded !== e.ded)
      begin errors++; $display("FAIL %s_beat: valid=%b sec=%b ded=%b data=%h, want 1 %b %b %h",
                               name, o_valid, o_sec, o_ded, o_data, e.sec, e.ded, e.data); end
    upd_model(e.sec, e.ded, 1'b0);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_sec_cnt !== CNTW'(m_sec) || o_ded_cnt !== CNTW'(m_ded))
      begin errors++; $display("FAIL %s_cnt: valid=%b sec_cnt=%0d ded_cnt=%0d, want 0 %0d %0d",
                               name, o_valid, o_sec_cnt, o_ded_cnt, m_sec, m_ded); end
  endtask

  task automatic test_directed();
    logic [CW-1:0] v;
    v = CW'(4'hF);  single_beat(v, "clean");
    checks++;
    if (o_sec_cnt !== '0 || o_ded_cnt !== '0)
      begin errors++; $display("FAIL clean_counters: %0d/%0d, want 0/0", o_sec_cnt, o_ded_cnt); end
    v = CW'(4'h7);  single_beat(v, "sec_data");
    v = CW'(4'hE);  single_beat(v, "sec_c0");
    checks++;
    if (o_sec_cnt !== CNTW'(2))
      begin errors++; $display("FAIL sec_count_two: sec_cnt=%0d, want 2", o_sec_cnt); end
    v = CW'(4'h3);  single_beat(v, "ded_pair");
    v = '0; v[CW-1] = 1'b1; v[1] = 1'b1;  single_beat(v, "ded_high");
    v[0] = 1'b1;  single_beat(v, "ded_invalid_pos");
  endtask

  // mode 0: always ready; mode 1: random valid/ready; mode 2: 4-cycle stall at first output.
  task automatic run_stream(input int mode, input bit clr_on_last);
    exp_t exp_q[$];
    exp_t e;
    int sent, total, consumed, stall_left;
    bit seen_first, stalled_prev;
    logic [DW-1:0] prev_data;
    logic prev_sec, prev_ded;
    total = cw_q.size(); sent = 0; consumed = 0; stall_left = 0;
    seen_first = 1'b0; stalled_prev = 1'b0;
    prev_data = '0; prev_sec = 1'b0; prev_ded = 1'b0;
    for (int cyc = 0; cyc < 3000 && consumed < total; cyc++) begin
      @(negedge clk);
      i_clr_cnt = 1'b0;
      checks++;
      if (o_sec_cnt !== CNTW'(m_sec) || o_ded_cnt !== CNTW'(m_ded))
        begin errors++; $display("FAIL stream_cnt: sec_cnt=%0d ded_cnt=%0d, want %0d %0d",
                                 o_sec_cnt, o_ded_cnt, m_sec, m_ded); end
      if (stalled_prev) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== prev_data || o_sec !== prev_sec || o_ded !== prev_ded)
          begin errors++; $display("FAIL stall_hold: valid=%b sec=%b ded=%b data=%h, want 1 %b %b %h",
                                   o_valid, o_sec, o_ded, o_data, prev_sec, prev_ded, prev_data); end
      end
      if (mode == 2 && o_valid === 1'b1 && !seen_first) begin seen_first = 1'b1; stall_left = 4; end
      if (mode == 1) i_ready = ($urandom_range(0, 3) != 0);
      else if (stall_left > 0) begin i_ready = 1'b0; stall_left--; end
      else i_ready = 1'b1;
      if (mode == 2 && seen_first && stall_left == 0 && i_ready) begin
        checks++;
        if (o_valid !== 1'b1)
          begin errors++; $display("FAIL back_to_back: o_valid=%b with %0d beats pending, want 1",
                                   o_valid, total - consumed); end
      end
      if (o_valid === 1'b1 && exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_beat: o_valid=1 with nothing outstanding, data=%h", o_data);
      end else if (o_valid === 1'b1 && i_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (o_data !== e.data || o_sec !== e.sec || o_ded !== e.ded)
          begin errors++; $display("FAIL stream_beat%0d: sec=%b ded=%b data=%h, want %b %b %h",
                                   consumed, o_sec, o_ded, o_data, e.sec, e.ded, e.data); end
        consumed++;
        if (clr_on_last && consumed == total) begin
          i_clr_cnt = 1'b1;
          upd_model(e.sec, e.ded, 1'b1);
        end else upd_model(e.sec, e.ded, 1'b0);
      end
      if (sent < total && (mode != 1 || $urandom_range(0, 3) != 0)) begin
        i_valid = 1'b1; i_cw = cw_q[sent];
      end else i_valid = 1'b0;
      #1;
      checks++;
      if (o_ready !== (!o_valid || i_ready))
        begin errors++; $display("FAIL ready: o_ready=%b with o_valid=%b i_ready=%b, want %b",
                                 o_ready, o_valid, i_ready, !o_valid || i_ready); end
      if (i_valid && o_ready === 1'b1) begin
        exp_q.push_back(ref_decode(cw_q[sent]));
        sent++;
      end
      stalled_prev = (o_valid === 1'b1) && !i_ready;
      prev_data = o_data; prev_sec = o_sec; prev_ded = o_ded;
    end
    if (consumed < total) begin
      checks++; errors++;
      $display("FAIL stream_timeout: consumed %0d of %0d beats", consumed, total);
    end
    @(negedge clk);
    i_valid = 1'b0; i_clr_cnt = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_sec_cnt !== CNTW'(m_sec) || o_ded_cnt !== CNTW'(m_ded))
      begin errors++; $display("FAIL stream_end: valid=%b sec_cnt=%0d ded_cnt=%0d, want 0 %0d %0d",
                               o_valid, o_sec_cnt, o_ded_cnt, m_sec, m_ded); end
    cw_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) cw_q.push_back(flip_bits(encode(rand_data()), $urandom_range(0, 3)));
    run_stream(1, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 6; n++) cw_q.push_back(flip_bits(encode(rand_data()), $urandom_range(0, 2)));
    run_stream(2, 1'b0);
  endtask

  task automatic test_saturation();
    @(negedge clk); i_clr_cnt = 1'b1; upd_model(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) cw_q.push_back(flip_bits(encode(rand_data()), 1));
    run_stream(0, 1'b0);
    checks++;
    if (o_sec_cnt !== 2'd3)
      begin errors++; $display("FAIL sec_saturate: sec_cnt=%0d, want 3", o_sec_cnt); end
    cw_q.push_back(flip_bits(encode(rand_data()), 1));
    run_stream(0, 1'b1);
    checks++;
    if (o_sec_cnt !== 2'd0)
      begin errors++; $display("FAIL clr_priority: sec_cnt=%0d, want 0", o_sec_cnt); end
  endtask

  task automatic test_reset_mid();
    cw_q.push_back(flip_bits(encode(rand_data()), 1));
    run_stream(0, 1'b0);
    @(negedge clk); i_ready = 1'b0; i_valid = 1'b1; i_cw = encode(rand_data());
    @(negedge clk); i_cw = encode(rand_data());
    @(negedge clk); i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1)
      begin errors++; $display("FAIL inflight_present: o_valid=%b, want 1", o_valid); end
    reset_n = 1'b0;
    upd_model(1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_sec_cnt !== '0 || o_ded_cnt !== '0 || o_ready !== 1'b1)
      begin errors++; $display("FAIL mid_reset: valid=%b cnt=%0d/%0d ready=%b, want 0 0/0 1",
                               o_valid, o_sec_cnt, o_ded_cnt, o_ready); end
    @(negedge clk); reset_n = 1'b1; i_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0 || o_sec_cnt !== '0 || o_ded_cnt !== '0)
        begin errors++; $display("FAIL stale_after_reset: valid=%b cnt=%0d/%0d, want 0 0/0",
                                 o_valid, o_sec_cnt, o_ded_cnt); end
    end
  endtask

  initial begin
    errors = 0; checks = 0; m_sec = 0; m_ded = 0;
    reset_n = 1'b0; i_valid = 1'b0; i_cw = '0; i_ready = 1'b1; i_clr_cnt = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
